// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing the syn_fifo write port among N_REQ requesters,
// tracking FIFO occupancy itself so the FIFO is never written while full.
module fifo_wr_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int BURST = 4,
   parameter int IDX_W = $clog2(N_REQ),
   parameter int LVL_W = $clog2(DEPTH)+1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [N_REQ-1:0]       req_i,
   input  logic [N_REQ*WIDTH-1:0] data_i,
   output logic [N_REQ-1:0]       gnt_o,
   input  logic                   fifo_rd_en_i,
   input  logic                   fifo_empty_i,
   input  logic                   fifo_full_i,
   output logic                   fifo_wr_en_o,
   output logic [WIDTH-1:0]       fifo_wdata_o,
   output logic [IDX_W-1:0]       owner_o,
   output logic                   busy_o,
   output logic [LVL_W-1:0]       level_o,
   output logic                   err_o
);
   localparam int BEAT_W = $clog2(BURST)+1;
   typedef enum logic {IDLE, OWN} state_t;
   state_t state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d, rr_q, rr_d, win;
   logic [BEAT_W-1:0] beats_q, beats_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [N_REQ-1:0] mask;
   logic wr_en_q, wr_en_d, err_q, err_d, space, acc, rd_acc, rel, found, start;
   assign space  = (level_q < LVL_W'(DEPTH)) & !fifo_full_i;
   assign acc    = (state_q == OWN) & req_i[owner_q] & space;
   assign gnt_o  = acc ? N_REQ'(1) << owner_q : '0;
   assign rd_acc = fifo_rd_en_i & !fifo_empty_i;
   assign rel    = (state_q == OWN) & ((acc & (beats_q == BEAT_W'(BURST-1))) | !req_i[owner_q]);
   // a releasing owner cannot win again with the word it just had accepted
   assign mask   = (state_q == IDLE) ? req_i : req_i & ~gnt_o;
   assign start  = ((state_q == IDLE) | rel) & found;
   always_comb begin
      found = 1'b0;
      win = '0;
      for (int i = N_REQ-1; i >= 0; i--)
         if (mask[(int'(rr_q) + i) % N_REQ]) begin
            found = 1'b1;
            win = IDX_W'((int'(rr_q) + i) % N_REQ);
         end
   end
   always_comb begin
      wr_en_d = acc;
      wdata_d = acc ? data_i[int'(owner_q)*WIDTH +: WIDTH] : wdata_q;
      level_d = level_q + LVL_W'(acc) - LVL_W'(rd_acc);
      err_d   = err_q | (wr_en_q & fifo_full_i);
      state_d = start ? OWN : rel ? IDLE : state_q;
      owner_d = start ? win : owner_q;
      rr_d    = start ? ((win == IDX_W'(N_REQ-1)) ? '0 : win + 1'b1) : rr_q;
      beats_d = start ? '0 : acc ? beats_q + 1'b1 : beats_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         owner_q <= '0;
         rr_q    <= '0;
         beats_q <= '0;
         level_q <= '0;
         wr_en_q <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         beats_q <= beats_d;
         level_q <= level_d;
         wr_en_q <= wr_en_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end
   assign fifo_wr_en_o = wr_en_q;
   assign fifo_wdata_o = wdata_q;
   assign owner_o      = owner_q;
   assign busy_o       = (state_q == OWN);
   assign level_o      = level_q;
   assign err_o        = err_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of fifo_wr_arbiter against a behavioural FIFO occupancy model.
module tb_fifo_wr_arbiter;
   logic        clk = 1'b0;
   logic        rst, rd, force_full;
   logic [3:0]  req, gnt;
   logic [31:0] data;
   logic        fifo_empty, fifo_full, wr_en, busy, err;
   logic [7:0]  wdata;
   logic [1:0]  owner;
   logic [4:0]  level;
   int cnt, n_chk, n_fail, g, exp_w, n;
   logic pend, ovf;
   fifo_wr_arbiter dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .gnt_o(gnt),
      .fifo_rd_en_i(rd), .fifo_empty_i(fifo_empty), .fifo_full_i(fifo_full),
      .fifo_wr_en_o(wr_en), .fifo_wdata_o(wdata), .owner_o(owner),
      .busy_o(busy), .level_o(level), .err_o(err)
   );
   always #5 clk = ~clk;
   // stands in for syn_fifo: counts writes landing and non-empty reads
   always @(posedge clk) begin
      if (rst) begin
         cnt <= 0;
         ovf <= 1'b0;
      end else begin
         cnt <= cnt + int'(wr_en && cnt < 16) - int'(rd && cnt > 0);
         if (wr_en && cnt == 16) ovf <= 1'b1;
      end
   end
   assign fifo_empty = (cnt == 0);
   assign fifo_full  = (cnt == 16) || force_full;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1; req = '0; rd = 1'b0; force_full = 1'b0; data = '0;
      nxt();
      rst = 1'b0;
   endtask
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      n_chk = 0; n_fail = 0;
      rst = 1'b1; req = '0; data = '0; rd = 1'b0; force_full = 1'b0;
      nxt(); nxt();
      rst = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_level", level, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_owner", owner, 0);
      chk("rst_err", err, 0);
      // single requester fills the FIFO
      req = 4'b0001; g = 0; pend = 1'b0; exp_w = 0;
      for (int i = 0; i < 40; i++) begin
         data[7:0] = 8'(100 + g);
         #1;
         if (pend) chk("s1_wdata", wdata, exp_w);
         chk("s1_wr_en", wr_en, pend);
         chk("s1_owner", owner, 0);
         chk("s1_gnt_other", gnt & 4'b1110, 0);
         pend = gnt[0];
         if (gnt[0]) begin
            exp_w = 100 + g;
            g++;
         end
         nxt();
      end
      chk("s1_grants", g, 16);
      chk("s1_level", level, 16);
      chk("s1_gnt_full", gnt, 0);
      chk("s1_err", err, 0);
      chk("s1_ovf", ovf, 0);
      // four requesters, continuous reads
      do_reset();
      req = 4'b1111; rd = 1'b1;
      #1;
      chk("s2_arb_gnt", gnt, 0);
      nxt();
      for (int k = 0; k < 32; k++) begin
         #1;
         chk("s2_gnt", gnt, 32'(1) << ((k / 4) % 4));
         chk("s2_level_le2", level <= 2, 1);
         nxt();
      end
      // owner 0 drops its request after two words
      do_reset();
      req = 4'b1111; rd = 1'b1;
      #1;
      chk("s3_arb_gnt", gnt, 0);
      nxt();
      #1; chk("s3_gnt0a", gnt, 4'b0001); nxt();
      #1; chk("s3_gnt0b", gnt, 4'b0001); nxt();
      req = 4'b1110;
      #1; chk("s3_drop_gnt", gnt, 0); nxt();
      req = 4'b1111;
      for (int k = 0; k < 16; k++) begin
         #1;
         if (k == 0) chk("s3_owner1", owner, 1);
         chk("s3_gnt", gnt, 32'(1) << (((k / 4) + 1) % 4));
         nxt();
      end
      // full FIFO: a read frees one slot, usable only the next cycle
      do_reset();
      req = 4'b0001;
      n = 0;
      while (level != 16 && n < 40) begin
         nxt();
         n++;
      end
      chk("s4_reach16", level, 16);
      nxt(); nxt(); nxt();
      chk("s4_busy", busy, 1);
      rd = 1'b1;
      #1;
      chk("s4_rd_gnt", gnt, 0);
      chk("s4_rd_level", level, 16);
      nxt();
      rd = 1'b0;
      #1;
      chk("s4_level15", level, 15);
      chk("s4_gnt", gnt, 4'b0001);
      nxt();
      #1;
      chk("s4_level16", level, 16);
      chk("s4_gnt_after", gnt, 0);
      chk("s4_ovf", ovf, 0);
      chk("s4_err", err, 0);
      // reset in the middle of owner 2's burst
      do_reset();
      req = 4'b0100; rd = 1'b1;
      #1; chk("s5_arb_gnt", gnt, 0); nxt();
      #1; chk("s5_gnt_a", gnt, 4'b0100); chk("s5_owner2", owner, 2); nxt();
      #1; chk("s5_gnt_b", gnt, 4'b0100); nxt();
      rst = 1'b1;
      nxt();
      rst = 1'b0; req = 4'b1111;
      #1;
      chk("s5_busy", busy, 0);
      chk("s5_gnt", gnt, 0);
      chk("s5_level", level, 0);
      chk("s5_wr_en", wr_en, 0);
      chk("s5_owner", owner, 0);
      nxt();
      #1;
      chk("s5_restart_gnt", gnt, 4'b0001);
      chk("s5_restart_owner", owner, 0);
      // externally forced full with free tracked space
      do_reset();
      req = 4'b0001;
      n = 0;
      while (level != 5 && n < 40) begin
         nxt();
         n++;
      end
      chk("s6_reach5", level, 5);
      req = 4'b0000;
      nxt();
      force_full = 1'b1; req = 4'b0001;
      #1;
      chk("s6_wr_en", wr_en, 0);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) #1;
         chk("s6_forced_gnt", gnt, 0);
         chk("s6_forced_level", level, 5);
         nxt();
      end
      force_full = 1'b0;
      #1;
      chk("s6_resume_gnt", gnt, 4'b0001);
      nxt();
      #1;
      chk("s6_level6", level, 6);
      chk("s6_err", err, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the team's synchronous FIFO (syn_fifo) between N_REQ independent requesters.
- Arbitration is round-robin. Each owner may write up to BURST consecutive words before ownership rotates.
- Tracks FIFO occupancy internally from its own writes and the FIFO read strobes, so the FIFO is never written when full (no overflow).
- Sits directly in front of syn_fifo. Its outputs drive the FIFO's wr_en_i and wdata_i; the FIFO's rd_en_i, empty_o and full_o are fed back to it.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 8, data word width; must equal the FIFO WIDTH.
- DEPTH, 16, FIFO depth; must equal the FIFO DEPTH.
- BURST, 4, maximum consecutive accepted words per ownership (>=1).
- IDX_W, $clog2(N_REQ), owner index width (derived).
- LVL_W, $clog2(DEPTH)+1, occupancy counter width (derived).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous active-high reset; shared with the FIFO.
- req_i  input  N_REQ  per-requester "word valid".
- data_i  input  N_REQ*WIDTH  requester k's word is at bits [k*WIDTH +: WIDTH].
- gnt_o  output  N_REQ  one-hot accept strobe, combinational; the word is consumed in a cycle where req_i[k]&gnt_o[k].
- fifo_rd_en_i  input  1  copy of the FIFO rd_en_i.
- fifo_empty_i  input  1  FIFO empty_o.
- fifo_full_i  input  1  FIFO full_o.
- fifo_wr_en_o  output  1  to FIFO wr_en_i, registered.
- fifo_wdata_o  output  WIDTH  to FIFO wdata_i, registered.
- owner_o  output  IDX_W  current owner index.
- busy_o  output  1  1 while in state OWN.
- level_o  output  LVL_W  tracked occupancy, 0..DEPTH.
- err_o  output  1  sticky; set if fifo_wr_en_o=1 while fifo_full_i=1.

Behaviour:
- Reset (rst_i=1 at a rising edge):
  - state=IDLE; fifo_wr_en_o=0; fifo_wdata_o=0; owner_o=0; rr_ptr=0; beat count=0; level_o=0; err_o=0.
  - gnt_o=0 whenever state=IDLE.
  - Reset mid-burst drops any in-flight word. The FIFO is reset by the same rst_i, so level_o=0 stays consistent.
- Space condition: space = (level_o < DEPTH) & !fifo_full_i.
- Arbitration:
  - Search req_i starting at rr_ptr, ascending with wrap; the first set bit wins.
  - On every ownership start: owner<=winner, rr_ptr<=winner+1 (mod N_REQ), beats<=0.
- IDLE:
  - If any req_i is set, go to OWN with the winner at the next edge.
  - There is no grant in the arbitration cycle, so the first word is accepted at the earliest one cycle after req rises.
- OWN, each cycle:
  - gnt_o[owner] = req_i[owner] & space.
  - On accept: fifo_wr_en_o<=1, fifo_wdata_o<=data_i[owner] slice, beats<=beats+1. Otherwise fifo_wr_en_o<=0 and fifo_wdata_o holds its value.
  - Write latency: a word accepted in cycle t appears on the FIFO port in cycle t+1.
- Release, evaluated in the same cycle:
  - Release occurs when (accept and beats+1==BURST) or req_i[owner]==0.
  - On release, arbitrate immediately among all req_i excluding the grant just given, starting from rr_ptr. The grant just given is computed with the old rr_ptr, and rr_ptr already points past the owner.
  - If a winner exists, stay in OWN with the new owner and beats=0 (zero bubble). Otherwise go to IDLE.
  - A sole requester is re-selected after BURST words.
  - Stalling on no-space does not release ownership; beats is held.
- Occupancy counter:
  - level_o <= level_o + wr_acc - rd_acc.
  - wr_acc is a grant in the current cycle (reserved at grant, not at FIFO write).
  - rd_acc = fifo_rd_en_i & !fifo_empty_i.
  - Simultaneous wr_acc and rd_acc: level unchanged.
  - No grant is given at level_o==DEPTH even if rd_acc is active that cycle; the freed slot is usable the next cycle.
  - level_o never exceeds DEPTH and never underflows, since rd_acc requires !empty.
- err_o: set when fifo_wr_en_o & fifo_full_i, cleared only by reset. It must stay 0 under correct integration.
- fifo_full_i asserted while level_o<DEPTH (mismatch): grants are blocked and no error is flagged.

Test Plan:
- Requester 0 only, holds req_i=0001 with data 100,101,..., no reads:
  - Exactly 16 grants are issued; FIFO wdata sequence is 100..115.
  - level_o=16; gnt_o=0 thereafter; err_o=0.
  - owner_o stays 0 across burst boundaries.
- All 4 requesters requesting continuously, FIFO read every cycle:
  - Grant order is 0,0,0,0,1,1,1,1,2×4,3×4,0... with no idle cycles between bursts.
  - level_o stays ≤2.
- req_i[owner] drops after 2 words in a burst:
  - The next requester is granted in the following cycle.
  - rr_ptr advances correctly; the dropped requester is not regranted before the other requesters.
- At level_o=16, reads and writes pending:
  - No grant in the read cycle; one grant the next cycle.
  - level_o goes 16→15→16; FIFO overflow_o is never asserted.
- rst_i pulsed for 1 cycle mid-burst (owner 2, beats=2):
  - Next cycle: busy_o=0, gnt_o=0, level_o=0, fifo_wr_en_o=0, owner_o=0.
  - Arbitration restarts from requester 0.
- Bench forces fifo_full_i=1 at level_o=5: no grants while forced; resumes on release; err_o=0.
